quad_encoder_window_counter: RTL and testbench



---
 rtl/quad_encoder_window_counter_pkg.sv | 36 +++
 rtl/quad_encoder_window_counter_sync_chain.sv | 26 ++
 rtl/quad_encoder_window_counter.sv | 104 ++++++++++
 tb/tb_quad_encoder_window_counter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_window_counter_pkg.sv
// Shared constants and helpers for the quadrature window counter.
// Holds step codes, A/B state codes and the saturating add.
package quad_encoder_window_counter_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    localparam logic signed [1:0] STEP_FWD  = 2'sb01;
    localparam logic signed [1:0] STEP_REV  = 2'sb11;
    localparam logic signed [1:0] STEP_NONE = 2'sb00;

    // Adds a step to a sign-extended accumulator and clamps the
    // result to the signed range of a width-bit register.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] acc,
        input logic signed [1:0]  step,
        input int                 width
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = $signed({acc[31], acc})
            + $signed({{31{step[1]}}, step});
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/quad_encoder_window_counter_sync_chain.sv
// Multi-flop synchroniser for one asynchronous encoder channel.
// Ports: clk, reset_n (async low), d (async in), q (synchronised out).
module quad_encoder_window_counter_sync_chain
    import quad_encoder_window_counter_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r <= '0;
        end else begin
            r <= {r[STAGES-2:0], d};
        end
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/quad_encoder_window_counter.sv
// Quadrature decoder that totals signed steps over one sample window.
// Ports: clk, reset_n, enc_a/enc_b, load_in/reset_in -> count/valid/dir/err.
module quad_encoder_window_counter
    import quad_encoder_window_counter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    load_in,
    input  logic                    reset_in,
    output logic signed [WIDTH-1:0] count_out,
    output logic                    valid_out,
    output logic                    dir_out,
    output logic                    err_out
);

    logic                    a_sync;
    logic                    b_sync;
    logic [1:0]              cur;
    logic [1:0]              prev;
    logic                    fwd;
    logic                    rev;
    logic                    bad;
    logic signed [1:0]       step;
    logic signed [WIDTH-1:0] acc;
    logic                    win_err;

    quad_encoder_window_counter_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync_a (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (enc_a),
        .q      (a_sync)
    );

    quad_encoder_window_counter_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync_b (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (enc_b),
        .q      (b_sync)
    );

    assign cur = {a_sync, b_sync};

    assign fwd = (prev == Q00 && cur == Q10)
              || (prev == Q10 && cur == Q11)
              || (prev == Q11 && cur == Q01)
              || (prev == Q01 && cur == Q00);

    assign rev = (prev == Q00 && cur == Q01)
              || (prev == Q01 && cur == Q11)
              || (prev == Q11 && cur == Q10)
              || (prev == Q10 && cur == Q00);

    // Both bits flipping means a state was skipped; direction unknown.
    assign bad = (prev ^ cur) == 2'b11;

    always_comb begin
        step = STEP_NONE;
        unique case (1'b1)
            fwd:     step = STEP_FWD;
            rev:     step = STEP_REV;
            default: step = STEP_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev      <= Q00;
            acc       <= '0;
            win_err   <= 1'b0;
            count_out <= '0;
            valid_out <= 1'b0;
            dir_out   <= 1'b1;
            err_out   <= 1'b0;
        end else begin
            prev <= cur;
            // A new window starts from this cycle's step so an edge
            // landing on the reset cycle is not lost.
            if (reset_in) begin
                acc     <= WIDTH'(step);
                win_err <= bad;
            end else begin
                acc     <= WIDTH'(sat_add(32'(acc), step, WIDTH));
                win_err <= win_err | bad;
            end
            valid_out <= load_in;
            // Publish the total as it stood before this cycle's step.
            if (load_in) begin
                count_out <= acc;
                dir_out   <= ~acc[WIDTH-1];
                err_out   <= win_err;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_window_counter.sv
// Randomised and directed bench for quad_encoder_window_counter.
// Runs a 16-bit and an 8-bit instance against a phase-based model.
module tb_quad_encoder_window_counter;

    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic load_in = 1'b0;
    logic reset_in = 1'b0;

    logic signed [15:0] c16;
    logic               v16, d16, e16;
    logic signed [7:0]  c8;
    logic               v8, d8, e8;

    int vectors = 0;
    int miscompares = 0;
    int phase = 0;

    always #5 clk = ~clk;

    quad_encoder_window_counter #(.WIDTH(16), .SYNC_STAGES(SYNC_STAGES)) dut16 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .load_in(load_in), .reset_in(reset_in),
        .count_out(c16), .valid_out(v16), .dir_out(d16), .err_out(e16)
    );

    quad_encoder_window_counter #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) dut8 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .load_in(load_in), .reset_in(reset_in),
        .count_out(c8), .valid_out(v8), .dir_out(d8), .err_out(e8)
    );

    // ---------------- reference model ----------------
    // Position is a phase index around the Gray cycle 00,10,11,01.
    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] enc_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int step_of(input logic [1:0] p, input logic [1:0] c);
        int d;
        d = (phase_of(c) - phase_of(p)) & 3;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return 0;
    endfunction

    function automatic bit bad_of(input logic [1:0] p, input logic [1:0] c);
        return ((phase_of(c) - phase_of(p)) & 3) == 2;
    endfunction

    function automatic int clamp(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // hist[j] holds the pin value sampled j+1 edges before the current one.
    logic [1:0] hist [0:SYNC_STAGES];
    int m_acc16, m_acc8;
    bit m_err;
    int x_cnt16, x_cnt8;
    bit x_dir16, x_dir8, x_err, x_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) hist[i] <= 2'b00;
            m_acc16 <= 0;
            m_acc8  <= 0;
            m_err   <= 1'b0;
            x_cnt16 <= 0;
            x_cnt8  <= 0;
            x_dir16 <= 1'b1;
            x_dir8  <= 1'b1;
            x_err   <= 1'b0;
            x_valid <= 1'b0;
        end else begin
            if (reset_in) begin
                m_acc16 <= step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]);
                m_acc8  <= step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]);
                m_err   <= bad_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]);
            end else begin
                m_acc16 <= clamp(m_acc16
                    + step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]), 16);
                m_acc8  <= clamp(m_acc8
                    + step_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]), 8);
                m_err   <= m_err | bad_of(hist[SYNC_STAGES], hist[SYNC_STAGES-1]);
            end
            x_valid <= load_in;
            if (load_in) begin
                x_cnt16 <= m_acc16;
                x_cnt8  <= m_acc8;
                x_dir16 <= (m_acc16 >= 0);
                x_dir8  <= (m_acc8 >= 0);
                x_err   <= m_err;
            end
            hist[0] <= {enc_a, enc_b};
            for (int i = 1; i <= SYNC_STAGES; i++) hist[i] <= hist[i-1];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("count16", int'(c16), x_cnt16);
        check("count8", int'(c8), x_cnt8);
        check("valid16", int'(v16), int'(x_valid));
        check("valid8", int'(v8), int'(x_valid));
        check("dir16", int'(d16), int'(x_dir16));
        check("dir8", int'(d8), int'(x_dir8));
        check("err16", int'(e16), int'(x_err));
        check("err8", int'(e8), int'(x_err));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int d, input int gap);
        phase = (phase + d) & 3;
        {enc_a, enc_b} = enc_of(phase);
        repeat (gap) tick();
    endtask

    task automatic run(input int n, input int d, input int gap);
        for (int i = 0; i < n; i++) move(d, gap);
        repeat (8) tick();
    endtask

    task automatic close_window();
        load_in = 1'b1;
        tick();
        load_in = 1'b0;
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        phase = 0;
        {enc_a, enc_b} = 2'b00;
        #1;
        check("rst_now_count", int'(c16), 0);
        check("rst_now_valid", int'(v16), 0);
        check("rst_now_err", int'(e16), 0);
        check("rst_now_dir", int'(d16), 1);
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) tick();
        check("reset_count", int'(c16), 0);
        check("reset_dir", int'(d16), 1);
        reset_n = 1'b1;
        repeat (4) tick();
        close_window();
        check("idle_count", int'(c16), 0);
        check("idle_dir", int'(d16), 1);

        // reset in the middle of a window
        run(20, 1, 2);
        close_window();
        check("pre_rst_count", int'(c16), 20);
        run(37, 1, 2);
        async_reset();
        run(5, 1, 3);
        close_window();
        check("post_rst_count", int'(c16), 5);

        // forward rotation in a 2000-clock window
        run(400, 1, 4);
        repeat (2000 - 1608 - 2) tick();
        close_window();
        check("fwd_count16", int'(c16), 400);
        check("fwd_count8", int'(c8), 127);
        check("fwd_dir", int'(d16), 1);
        check("fwd_err", int'(e16), 0);

        // reverse rotation
        run(100, -1, 4);
        close_window();
        check("rev_count16", int'(c16), -100);
        check("rev_raw16", int'(c16) & 32'hFFFF, 32'hFF9C);
        check("rev_dir", int'(d16), 0);

        // illegal jump then a clean window
        move(2, 4);
        run(10, 1, 3);
        close_window();
        check("ill_count", int'(c16), 10);
        check("ill_err", int'(e16), 1);
        run(4, 1, 3);
        close_window();
        check("clean_err", int'(e16), 0);

        // saturation at the narrow width
        run(300, 1, 1);
        close_window();
        check("sat_hi8", int'(c8), 127);
        check("sat_hi16", int'(c16), 300);
        run(300, -1, 1);
        close_window();
        check("sat_lo8", int'(c8), -128);
        check("sat_lo16", int'(c16), -300);
        check("sat_lo_dir", int'(d8), 0);

        // load and reset together with a step on that cycle
        run(7, 1, 3);
        move(1, 0);
        repeat (SYNC_STAGES) tick();
        load_in = 1'b1;
        reset_in = 1'b1;
        tick();
        load_in = 1'b0;
        reset_in = 1'b0;
        check("both_count", int'(c16), 7);
        run(2, 1, 3);
        close_window();
        check("both_next", int'(c16), 3);

        // step on the load cycle of a load-then-reset pair
        run(6, 1, 3);
        move(1, 0);
        repeat (SYNC_STAGES) tick();
        close_window();
        check("split_count", int'(c16), 6);
        run(2, 1, 3);
        close_window();
        check("split_next", int'(c16), 2);

        // random windows
        for (int w = 0; w < 24; w++) begin
            int n, bias, style;
            n = $urandom_range(0, 60);
            bias = $urandom_range(0, 1);
            for (int s = 0; s < n; s++) begin
                int r, d;
                r = $urandom_range(0, 99);
                if (r < 3) d = 2;
                else if (r < 85) d = bias ? 1 : -1;
                else d = bias ? -1 : 1;
                move(d, $urandom_range(1, 5));
            end
            repeat ($urandom_range(0, 6)) tick();
            if (w == 11) async_reset();
            style = $urandom_range(0, 3);
            case (style)
                0: close_window();
                1: begin
                    load_in = 1'b1;
                    reset_in = 1'b1;
                    tick();
                    load_in = 1'b0;
                    reset_in = 1'b0;
                end
                2: begin
                    load_in = 1'b1;
                    tick();
                    load_in = 1'b0;
                end
                default: begin
                    reset_in = 1'b1;
                    tick();
                    reset_in = 1'b0;
                end
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (8) tick();
        close_window();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
